// File: rtl/usbh_data_tx_seq_if.sv
// Byte-stream bundle between the transfer engine, the DATA packet sequencer
// and the TX serializer. The slave side is the sequencer; the master side
// drives the control, payload source and serializer-ready signals.
interface usbh_data_tx_seq_if #(
  parameter int LEN_W = 10
);
  // packet control
  logic             start_i;
  logic [7:0]       pid_i;
  logic [LEN_W-1:0] len_i;
  logic             abort_i;
  // payload source
  logic [7:0]       in_data_i;
  logic             in_valid_i;
  logic             in_ready_o;
  // serializer sink
  logic [7:0]       tx_data_o;
  logic             tx_valid_o;
  logic             tx_ready_i;
  logic             tx_last_o;
  // status
  logic             busy_o;
  logic             done_o;
  logic             aborted_o;

  modport slave (
    input  start_i, pid_i, len_i, abort_i,
    input  in_data_i, in_valid_i, tx_ready_i,
    output in_ready_o, tx_data_o, tx_valid_o, tx_last_o,
    output busy_o, done_o, aborted_o
  );

  modport master (
    output start_i, pid_i, len_i, abort_i,
    output in_data_i, in_valid_i, tx_ready_i,
    input  in_ready_o, tx_data_o, tx_valid_o, tx_last_o,
    input  busy_o, done_o, aborted_o
  );
endinterface

// File: rtl/usbh_data_tx_seq.sv
// USB DATA packet sequencer: PID, payload pass-through, then inverted CRC16
// (low byte first). The CRC is the USB reflected CRC16 (poly 0x8005, LSB-first)
// held in crc_q and advanced only on accepted payload bytes.

// One-byte step of the reflected USB CRC16, data bits consumed LSB first.
module usbh_crc16 (
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);
  logic [15:0] c;

  // Eight serial shift/xor steps unrolled into one combinational stage
  always_comb begin
    c = crc_i;
    for (int b = 0; b < 8; b++) begin
      if (c[0] ^ data_i[b]) c = (c >> 1) ^ 16'hA001;
      else                  c = c >> 1;
    end
    crc_o = c;
  end
endmodule

module usbh_data_tx_seq #(
  parameter int MAX_LEN = 1023,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  usbh_data_tx_seq_if.slave bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PID    = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CRC_LO = 3'd3;
  localparam logic [2:0] S_CRC_HI = 3'd4;

  localparam logic [15:0] CRC_SEED = 16'hFFFF;

  logic [2:0]       state_q, state_d;
  logic [7:0]       pid_q, pid_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [15:0]      crc_q, crc_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic [15:0]      crc_nxt;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_last;
  logic             in_ready;
  logic             tx_hs;

  usbh_crc16 u_crc (
    .crc_i  (crc_q),
    .data_i (bus.in_data_i),
    .crc_o  (crc_nxt)
  );

  // Output mux: every byte source is selected by state alone, so the PID and
  // CRC bytes hold naturally while the serializer stalls. DATA is a straight
  // combinational pass-through in both directions.
  always_comb begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      S_PID: begin
        tx_data  = pid_q;
        tx_valid = 1'b1;
      end
      S_DATA: begin
        tx_data  = bus.in_data_i;
        tx_valid = bus.in_valid_i;
        in_ready = bus.tx_ready_i;
      end
      S_CRC_LO: begin
        tx_data  = ~crc_q[7:0];
        tx_valid = 1'b1;
      end
      S_CRC_HI: begin
        tx_data  = ~crc_q[15:8];
        tx_valid = 1'b1;
        tx_last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign tx_hs = tx_valid & bus.tx_ready_i;

  // Next-state: packet sequencing, CRC/length bookkeeping, and the abort
  // override which wins over any completion in the same cycle.
  always_comb begin
    state_d   = state_q;
    pid_d     = pid_q;
    rem_d     = rem_q;
    crc_d     = crc_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.abort_i) begin
          pid_d   = bus.pid_i;
          rem_d   = bus.len_i;
          crc_d   = CRC_SEED;
          state_d = S_PID;
        end
      end
      S_PID: begin
        if (tx_hs) state_d = (rem_q == '0) ? S_CRC_LO : S_DATA;
      end
      S_DATA: begin
        // rem_q >= 1 whenever DATA is entered, so the decrement cannot wrap
        if (tx_hs) begin
          crc_d = crc_nxt;
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = S_CRC_LO;
        end
      end
      S_CRC_LO: begin
        if (tx_hs) state_d = S_CRC_HI;
      end
      S_CRC_HI: begin
        if (tx_hs) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && bus.abort_i) begin
      state_d   = S_IDLE;
      done_d    = 1'b0;
      aborted_d = 1'b1;
    end
  end

  // State registers; reset drops straight to IDLE without status pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      pid_q     <= 8'h00;
      rem_q     <= '0;
      crc_q     <= CRC_SEED;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pid_q     <= pid_d;
      rem_q     <= rem_d;
      crc_q     <= crc_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.tx_data_o  = tx_data;
  assign bus.tx_valid_o = tx_valid;
  assign bus.tx_last_o  = tx_last;
  assign bus.in_ready_o = in_ready;
  assign bus.busy_o     = (state_q != S_IDLE);
  assign bus.done_o     = done_q;
  assign bus.aborted_o  = aborted_q;
endmodule

// File: tb/tb_usbh_data_tx_seq.sv
// Directed bench for the USB DATA packet sequencer.
module tb_usbh_data_tx_seq;
  localparam int MAX_LEN = 1023;
  localparam int LEN_W   = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  usbh_data_tx_seq_if #(.LEN_W(LEN_W)) bus ();

  usbh_data_tx_seq #(.MAX_LEN(MAX_LEN)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] pay[$];
  logic [7:0] got[$];
  logic       glast[$];

  logic [7:0] s_data;
  logic       s_valid, s_ready, s_last, s_done, s_abt, s_busy, s_inrdy;

  int n_done, n_abt, cyc_last, cyc_done, cyc_first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int b = 0; b < 8; b++)
      r = (r[0] ^ d[b]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  // one clock: inputs already driven, sample mid-cycle, return at posedge+1
  task automatic step();
    @(negedge clk);
    s_data  = bus.tx_data_o;
    s_valid = bus.tx_valid_o;
    s_ready = bus.tx_ready_i;
    s_last  = bus.tx_last_o;
    s_done  = bus.done_o;
    s_abt   = bus.aborted_o;
    s_busy  = bus.busy_o;
    s_inrdy = bus.in_ready_o;
    @(posedge clk);
    #1;
  endtask

  task automatic run_pkt(input bit do_start, input logic [7:0] pid, input int len,
                         input bit stall, input int abort_pos, input int busy_cyc,
                         input bit chain, input logic [7:0] c_pid, input int c_len,
                         input int stop_after);
    int idx, pos, prev_pos;
    bit prev_stall, tmo, ab_sent, chain_go;
    logic [7:0] prev_data;
    got.delete(); glast.delete();
    n_done = 0; n_abt = 0; cyc_last = -1; cyc_done = -1; cyc_first = -1;
    idx = 0; prev_stall = 0; prev_pos = 0; prev_data = 8'h00;
    tmo = 1; ab_sent = 0; chain_go = 0;
    if (do_start) begin
      bus.start_i = 1'b1; bus.pid_i = pid; bus.len_i = LEN_W'(len);
      step();
      bus.start_i = 1'b0;
    end
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (stop_after >= 0 && cyc == stop_after) begin tmo = 0; break; end
      bus.tx_ready_i = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_valid_i = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_data_i  = (idx < len) ? pay[idx] : 8'h00;
      bus.abort_i    = (abort_pos >= 0 && got.size() == abort_pos && !ab_sent);
      if (bus.abort_i) ab_sent = 1;
      bus.start_i    = (cyc == busy_cyc) || chain_go;
      if (cyc == busy_cyc) begin bus.pid_i = 8'h5A; bus.len_i = LEN_W'(3); end
      step();
      pos = got.size();
      if (prev_stall && pos == prev_pos && (pos == 0 || pos > len)) begin
        chk("hold_valid", s_valid, 1);
        chk("hold_data", s_data, prev_data);
      end
      prev_stall = s_valid && !s_ready;
      prev_pos   = pos;
      prev_data  = s_data;
      if (s_valid && s_ready) begin
        if (cyc_first < 0) cyc_first = cyc;
        got.push_back(s_data);
        glast.push_back(s_last);
        if (s_inrdy && bus.in_valid_i) idx++;
        if (s_last) begin
          cyc_last = cyc;
          if (chain) begin
            chain_go = 1; bus.pid_i = c_pid; bus.len_i = LEN_W'(c_len);
          end
        end
      end
      if (s_done) begin n_done++; cyc_done = cyc; tmo = 0; break; end
      if (s_abt)  begin n_abt++; tmo = 0; break; end
    end
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    if (tmo) chk("timeout", tmo, 0);
  endtask

  task automatic check_pkt(input string tag, input logic [7:0] pid, input int len);
    logic [15:0] c, r;
    logic [7:0]  exp[$];
    int mis, nl;
    c = 16'hFFFF;
    for (int i = 0; i < len; i++) c = crc16(c, pay[i]);
    exp.push_back(pid);
    for (int i = 0; i < len; i++) exp.push_back(pay[i]);
    exp.push_back(~c[7:0]);
    exp.push_back(~c[15:8]);
    chk({tag, "_nbytes"}, got.size(), len + 3);
    mis = 0;
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (got[i] !== exp[i]) mis++;
    chk({tag, "_byte_mis"}, mis, 0);
    nl = 0;
    foreach (glast[i]) if (glast[i]) nl++;
    chk({tag, "_last_cnt"}, nl, 1);
    if (glast.size() > 0) chk({tag, "_last_pos"}, glast[glast.size()-1], 1);
    chk({tag, "_done"}, n_done, 1);
    chk({tag, "_done_lat"}, cyc_done, cyc_last + 1);
    chk({tag, "_no_abt"}, n_abt, 0);
    r = 16'hFFFF;
    for (int i = 1; i < got.size(); i++) r = crc16(r, got[i]);
    chk({tag, "_residual"}, r, 16'hB001);
  endtask

  initial begin
    bus.start_i = 0; bus.pid_i = 0; bus.len_i = 0; bus.abort_i = 0;
    bus.in_data_i = 0; bus.in_valid_i = 0; bus.tx_ready_i = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", bus.tx_valid_o, 0);
    chk("rst_in_ready", bus.in_ready_o, 0);
    chk("rst_tx_last",  bus.tx_last_o, 0);
    chk("rst_busy",     bus.busy_o, 0);
    chk("rst_done",     bus.done_o, 0);
    chk("rst_aborted",  bus.aborted_o, 0);
    chk("rst_tx_data",  bus.tx_data_o, 0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", s_busy, 0);

    // ZLP
    pay.delete();
    run_pkt(1, 8'hC3, 0, 0, -1, -1, 0, 8'h00, 0, -1);
    check_pkt("zlp", 8'hC3, 0);
    chk("zlp_first_lat", cyc_first, 0);
    if (got.size() == 3) begin
      chk("zlp_b0", got[0], 8'hC3);
      chk("zlp_b1", got[1], 8'h00);
      chk("zlp_b2", got[2], 8'h00);
    end

    // four-byte counting payload
    pay = '{8'h00, 8'h01, 8'h02, 8'h03};
    run_pkt(1, 8'h4B, 4, 0, -1, -1, 0, 8'h00, 0, -1);
    check_pkt("len4", 8'h4B, 4);

    // ASCII "123456789": USB CRC16 check value 0xB4C8, low byte first
    pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_pkt(1, 8'hC3, 9, 0, -1, -1, 0, 8'h00, 0, -1);
    check_pkt("ascii9", 8'hC3, 9);
    if (got.size() == 12) begin
      chk("ascii9_crc_lo", got[10], 8'hC8);
      chk("ascii9_crc_hi", got[11], 8'hB4);
    end

    // random stalls on both sides
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'($urandom_range(0, 255)));
    run_pkt(1, 8'h4B, 64, 1, -1, -1, 0, 8'h00, 0, -1);
    check_pkt("stall64", 8'h4B, 64);

    // abort on the third DATA byte (PID + 2 bytes already out)
    pay.delete();
    for (int i = 0; i < 10; i++) pay.push_back(8'(8'hA0 + i));
    run_pkt(1, 8'h4B, 10, 0, 3, -1, 0, 8'h00, 0, -1);
    chk("ab_nbytes", got.size(), 4);
    chk("ab_valid",  s_valid, 0);
    chk("ab_pulse",  n_abt, 1);
    chk("ab_nodone", n_done, 0);
    chk("ab_busy",   s_busy, 0);
    step();
    chk("ab_pulse_1cyc", s_abt, 0);
    chk("ab_done_late",  s_done, 0);
    pay.delete();
    run_pkt(1, 8'hC3, 0, 0, -1, -1, 0, 8'h00, 0, -1);
    check_pkt("post_ab", 8'hC3, 0);

    // start while busy is ignored; start in the done cycle chains a ZLP
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_pkt(1, 8'hC3, 5, 0, -1, 2, 1, 8'h4B, 0, -1);
    check_pkt("busy_start", 8'hC3, 5);
    run_pkt(0, 8'h4B, 0, 0, -1, -1, 0, 8'h00, 0, -1);
    check_pkt("chain", 8'h4B, 0);
    chk("chain_first_lat", cyc_first, 0);

    // abort together with start in IDLE: nothing happens
    bus.start_i = 1; bus.abort_i = 1; bus.pid_i = 8'hC3; bus.len_i = 0;
    step();
    bus.start_i = 0; bus.abort_i = 0;
    step();
    chk("idle_abort_busy",  s_busy, 0);
    chk("idle_abort_valid", s_valid, 0);
    chk("idle_abort_pulse", s_abt, 0);

    // reset mid-DATA of a max-length packet
    pay.delete();
    for (int i = 0; i < MAX_LEN; i++) pay.push_back(8'($urandom_range(0, 255)));
    run_pkt(1, 8'hC3, MAX_LEN, 0, -1, -1, 0, 8'h00, 0, 50);
    bus.in_valid_i = 1; bus.tx_ready_i = 1; bus.in_data_i = 8'hFF;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_tx_valid", bus.tx_valid_o, 0);
    chk("mrst_in_ready", bus.in_ready_o, 0);
    chk("mrst_tx_last",  bus.tx_last_o, 0);
    chk("mrst_busy",     bus.busy_o, 0);
    chk("mrst_done",     bus.done_o, 0);
    chk("mrst_aborted",  bus.aborted_o, 0);
    chk("mrst_tx_data",  bus.tx_data_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("mrst_no_pulse", {s_done, s_abt, s_busy}, 3'b000);
    run_pkt(1, 8'h4B, MAX_LEN, 0, -1, -1, 0, 8'h00, 0, -1);
    check_pkt("maxlen", 8'h4B, MAX_LEN);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
